// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: XNOR tap table, next-word helpers and checker state encoding.
package lfsr_pkg;

    localparam int unsigned LFSR_MAX_BITS = 128;

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Tap numbers packed MSB-first, 8 bits each, zero-terminated; tap k means w[k-1].
    function automatic logic [47:0] lfsr_tap_list(input int unsigned n);
        case (n)
            3:   return {8'd3,   8'd2,   32'd0};
            4:   return {8'd4,   8'd3,   32'd0};
            5:   return {8'd5,   8'd3,   32'd0};
            6:   return {8'd6,   8'd5,   32'd0};
            7:   return {8'd7,   8'd6,   32'd0};
            8:   return {8'd8,   8'd6,   8'd5,   8'd4,   16'd0};
            9:   return {8'd9,   8'd5,   32'd0};
            10:  return {8'd10,  8'd7,   32'd0};
            11:  return {8'd11,  8'd9,   32'd0};
            12:  return {8'd12,  8'd6,   8'd4,   8'd1,   16'd0};
            13:  return {8'd13,  8'd4,   8'd3,   8'd1,   16'd0};
            14:  return {8'd14,  8'd5,   8'd3,   8'd1,   16'd0};
            15:  return {8'd15,  8'd14,  32'd0};
            16:  return {8'd16,  8'd15,  8'd13,  8'd4,   16'd0};
            17:  return {8'd17,  8'd14,  32'd0};
            18:  return {8'd18,  8'd11,  32'd0};
            19:  return {8'd19,  8'd6,   8'd2,   8'd1,   16'd0};
            20:  return {8'd20,  8'd17,  32'd0};
            21:  return {8'd21,  8'd19,  32'd0};
            22:  return {8'd22,  8'd21,  32'd0};
            23:  return {8'd23,  8'd18,  32'd0};
            24:  return {8'd24,  8'd23,  8'd22,  8'd17,  16'd0};
            25:  return {8'd25,  8'd22,  32'd0};
            26:  return {8'd26,  8'd6,   8'd2,   8'd1,   16'd0};
            27:  return {8'd27,  8'd5,   8'd2,   8'd1,   16'd0};
            28:  return {8'd28,  8'd25,  32'd0};
            29:  return {8'd29,  8'd27,  32'd0};
            30:  return {8'd30,  8'd6,   8'd4,   8'd1,   16'd0};
            31:  return {8'd31,  8'd28,  32'd0};
            32:  return {8'd32,  8'd22,  8'd2,   8'd1,   16'd0};
            33:  return {8'd33,  8'd20,  32'd0};
            34:  return {8'd34,  8'd27,  8'd2,   8'd1,   16'd0};
            35:  return {8'd35,  8'd33,  32'd0};
            36:  return {8'd36,  8'd25,  32'd0};
            37:  return {8'd37,  8'd5,   8'd4,   8'd3,   8'd2,   8'd1};
            38:  return {8'd38,  8'd6,   8'd5,   8'd1,   16'd0};
            39:  return {8'd39,  8'd35,  32'd0};
            40:  return {8'd40,  8'd38,  8'd21,  8'd19,  16'd0};
            41:  return {8'd41,  8'd38,  32'd0};
            42:  return {8'd42,  8'd41,  8'd20,  8'd19,  16'd0};
            43:  return {8'd43,  8'd42,  8'd38,  8'd37,  16'd0};
            44:  return {8'd44,  8'd43,  8'd18,  8'd17,  16'd0};
            45:  return {8'd45,  8'd44,  8'd42,  8'd41,  16'd0};
            46:  return {8'd46,  8'd45,  8'd26,  8'd25,  16'd0};
            47:  return {8'd47,  8'd42,  32'd0};
            48:  return {8'd48,  8'd47,  8'd21,  8'd20,  16'd0};
            49:  return {8'd49,  8'd40,  32'd0};
            50:  return {8'd50,  8'd49,  8'd24,  8'd23,  16'd0};
            51:  return {8'd51,  8'd50,  8'd36,  8'd35,  16'd0};
            52:  return {8'd52,  8'd49,  32'd0};
            53:  return {8'd53,  8'd52,  8'd38,  8'd37,  16'd0};
            54:  return {8'd54,  8'd53,  8'd18,  8'd17,  16'd0};
            55:  return {8'd55,  8'd31,  32'd0};
            56:  return {8'd56,  8'd55,  8'd35,  8'd34,  16'd0};
            57:  return {8'd57,  8'd50,  32'd0};
            58:  return {8'd58,  8'd39,  32'd0};
            59:  return {8'd59,  8'd58,  8'd38,  8'd37,  16'd0};
            60:  return {8'd60,  8'd59,  32'd0};
            61:  return {8'd61,  8'd60,  8'd46,  8'd45,  16'd0};
            62:  return {8'd62,  8'd61,  8'd6,   8'd5,   16'd0};
            63:  return {8'd63,  8'd62,  32'd0};
            64:  return {8'd64,  8'd63,  8'd61,  8'd60,  16'd0};
            128: return {8'd128, 8'd126, 8'd101, 8'd99,  16'd0};
            default: return '0;
        endcase
    endfunction

    // Left-associative XNOR chain over the taps, first listed tap outermost-left.
    function automatic logic lfsr_fb(input int unsigned n, input logic [127:0] w);
        logic [47:0] taps;
        logic [7:0]  tap;
        logic [6:0]  idx;
        logic        fb;
        logic        first;
        taps  = lfsr_tap_list(n);
        fb    = 1'b0;
        first = 1'b1;
        for (int unsigned k = 0; k < 6; k++) begin
            tap  = taps[47:40];
            taps = taps << 8;
            if (tap != 8'd0) begin
                idx = 7'(tap - 8'd1);
                fb  = first ? w[idx] : (fb ~^ w[idx]);
                first = 1'b0;
            end
        end
        return fb;
    endfunction

    // Full next-state word for an n-bit register held right-aligned in 128 bits.
    function automatic logic [127:0] lfsr_next(input int unsigned n, input logic [127:0] w);
        logic [127:0] mask;
        mask = (n >= 128) ? '1 : ((128'd1 << n) - 128'd1);
        return {w[126:0], lfsr_fb(n, w)} & mask;
    endfunction

endpackage

// File: rtl/lfsr_next_word.sv
// Combinational next-word function of the XNOR LFSR: shift left, feedback into bit 0.
module lfsr_next_word
    import lfsr_pkg::*;
#(
    parameter int unsigned NUM_BITS = 32
) (
    input  logic [NUM_BITS-1:0] word_i,
    output logic [NUM_BITS-1:0] word_o
);

    logic [LFSR_MAX_BITS-1:0] wide;
    logic                     fb;

    assign wide   = 128'(word_i);
    assign fb     = lfsr_fb(NUM_BITS, wide);
    assign word_o = {word_i[NUM_BITS-2:0], fb};

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: seeds from the incoming stream, locks after LOCK_COUNT
// correct predictions, then flywheels its own sequence and counts mismatched words.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned NUM_BITS    = 32,
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned LOSS_THRESH = 3,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    input  logic                 i_Data_DV,
    input  logic [NUM_BITS-1:0]  i_Data,
    input  logic                 i_Resync,
    input  logic                 i_Clear_Cnt,
    output logic                 o_Locked,
    output logic                 o_Err,
    output logic [CNT_WIDTH-1:0] o_Err_Count
);

    logic [0:0]           state_q,  state_d;
    logic [NUM_BITS-1:0]  expect_q, expect_d;
    logic                 valid_q,  valid_d;
    logic [7:0]           match_q,  match_d;
    logic [7:0]           miss_q,   miss_d;
    logic                 err_q,    err_d;
    logic [CNT_WIDTH-1:0] cnt_q,    cnt_d;

    logic [NUM_BITS-1:0]  nxt_data;
    logic [NUM_BITS-1:0]  nxt_expect;
    logic                 hit;
    logic                 all_ones;
    logic                 count_err;

    lfsr_next_word #(.NUM_BITS(NUM_BITS)) u_next_data (
        .word_i (i_Data),
        .word_o (nxt_data)
    );

    lfsr_next_word #(.NUM_BITS(NUM_BITS)) u_next_expect (
        .word_i (expect_q),
        .word_o (nxt_expect)
    );

    assign hit      = (i_Data == expect_q);
    assign all_ones = &i_Data;

    // Search/lock FSM plus match and miss run-length tracking.
    always_comb begin
        state_d   = state_q;
        expect_d  = expect_q;
        valid_d   = valid_q;
        match_d   = match_q;
        miss_d    = miss_q;
        err_d     = 1'b0;
        count_err = 1'b0;

        if (i_Resync) begin
            state_d = ST_SEARCH;
            match_d = '0;
            miss_d  = '0;
            valid_d = 1'b0;
        end else if (i_Data_DV) begin
            if (state_q == ST_SEARCH) begin
                expect_d = nxt_data;
                if (all_ones) begin
                    // XNOR lock-up word: never usable as a seed.
                    match_d = '0;
                    valid_d = 1'b0;
                end else begin
                    valid_d = 1'b1;
                    if (hit && valid_q) begin
                        match_d = match_q + 8'd1;
                        if (match_q + 8'd1 == 8'(LOCK_COUNT)) begin
                            state_d = ST_LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
            end else begin
                expect_d = nxt_expect;
                if (!hit) begin
                    err_d     = 1'b1;
                    count_err = 1'b1;
                    if (miss_q + 8'd1 == 8'(LOSS_THRESH)) begin
                        state_d = ST_SEARCH;
                        match_d = '0;
                        miss_d  = '0;
                        valid_d = 1'b0;
                    end else begin
                        miss_d = miss_q + 8'd1;
                    end
                end else begin
                    miss_d = '0;
                end
            end
        end
    end

    // Saturating error counter; a same-cycle clear wins over the increment.
    always_comb begin
        cnt_d = cnt_q;
        if (i_Clear_Cnt) begin
            cnt_d = '0;
        end else if (count_err && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= ST_SEARCH;
            expect_q <= '0;
            valid_q  <= 1'b0;
            match_q  <= '0;
            miss_q   <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            expect_q <= expect_d;
            valid_q  <= valid_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_Locked    = (state_q == ST_LOCKED);
    assign o_Err       = err_q;
    assign o_Err_Count = cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker (8-bit LFSR, lock 4, loss 3, 2-bit counter).
module tb_lfsr_checker;

    localparam int LC = 4;
    localparam int LT = 3;
    localparam int CMAX = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dv = 1'b0;
    logic [7:0] data = 8'h00;
    logic       resync = 1'b0;
    logic       clr = 1'b0;
    logic       locked;
    logic       err;
    logic [1:0] cnt;

    lfsr_checker #(
        .NUM_BITS    (8),
        .LOCK_COUNT  (LC),
        .LOSS_THRESH (LT),
        .CNT_WIDTH   (2)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_n     (rst_n),
        .i_Data_DV   (dv),
        .i_Data      (data),
        .i_Resync    (resync),
        .i_Clear_Cnt (clr),
        .o_Locked    (locked),
        .o_Err       (err),
        .o_Err_Count (cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int locked;
        int err;
        int cnt;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    int         m_locked, m_valid, m_match, m_miss, m_cnt, m_err;
    logic [7:0] m_exp;
    logic [7:0] g;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Taps 8,6,5,4: a 4-term XNOR chain equals the inverted parity of the taps.
    function automatic logic [7:0] nxt8(input logic [7:0] w);
        return {w[6:0], ~(w[7] ^ w[5] ^ w[4] ^ w[3])};
    endfunction

    task automatic model_reset();
        m_locked = 0; m_valid = 0; m_match = 0; m_miss = 0; m_cnt = 0; m_err = 0;
        m_exp = 8'h00;
    endtask

    task automatic model_step(input bit d_v, input logic [7:0] d, input bit rs, input bit cl);
        int bump;
        bump  = 0;
        m_err = 0;
        if (rs) begin
            m_locked = 0; m_match = 0; m_miss = 0; m_valid = 0;
        end else if (d_v) begin
            if (m_locked == 0) begin
                if (d == 8'hFF) begin
                    m_match = 0; m_valid = 0;
                end else begin
                    m_match = (m_valid != 0 && d == m_exp) ? m_match + 1 : 0;
                    m_valid = 1;
                    m_exp   = nxt8(d);
                    if (m_match == LC) m_locked = 1;
                end
            end else begin
                if (d != m_exp) begin
                    m_err = 1; bump = 1; m_miss++;
                    if (m_miss == LT) begin
                        m_locked = 0; m_match = 0; m_valid = 0; m_miss = 0;
                    end
                end else begin
                    m_miss = 0;
                end
                m_exp = nxt8(m_exp);
            end
        end
        if (cl) m_cnt = 0;
        else if (bump != 0) m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
    endtask

    // One input cycle: drive at the falling edge, record the expected response.
    task automatic drive(input bit d_v, input logic [7:0] d, input bit rs, input bit cl);
        exp_t e;
        @(negedge clk);
        dv = d_v; data = d; resync = rs; clr = cl;
        model_step(d_v, d, rs, cl);
        e.locked = m_locked; e.err = m_err; e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic send_good();
        drive(1'b1, g, 1'b0, 1'b0);
        g = nxt8(g);
    endtask

    task automatic send_bad();
        drive(1'b1, g ^ 8'h01, 1'b0, 1'b0);
        g = nxt8(g);
    endtask

    task automatic gap();
        drive(1'b0, 8'($urandom), 1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Feeds clean words until lock, returning how many valid words it took.
    task automatic relock(output int n);
        n = 0;
        while (!locked && n < 20) begin
            if ($urandom_range(0, 2) == 0) gap();
            send_good();
            settle();
            n++;
        end
    endtask

    // Monitor: compare each registered response one cycle after its sampling edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_locked", int'(locked), e.locked);
                chk("sb_err", int'(err), e.err);
                chk("sb_count", int'(cnt), e.cnt);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bit dvb;
        logic [7:0] d;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("reset_locked", int'(locked), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_count", int'(cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Seed 00 -> 01 03 07 0F: lock one cycle after 0F
        g = 8'h00;
        repeat (4) send_good();
        settle();
        chk("not_locked_after_07", int'(locked), 0);
        send_good();
        settle();
        chk("locked_after_0F", int'(locked), 1);
        chk("no_err_during_search", int'(cnt), 0);

        // Single corrupted word 1F in place of 1E, then the clean stream
        send_bad();
        settle();
        chk("single_err_pulse", int'(err), 1);
        chk("single_err_count", int'(cnt), 1);
        chk("single_err_still_locked", int'(locked), 1);
        repeat (8) begin
            if ($urandom_range(0, 1) == 0) gap();
            send_good();
        end

        // Three consecutive wrong words force loss of lock
        repeat (3) send_bad();
        settle();
        chk("loss_unlocked", int'(locked), 0);
        chk("loss_count", int'(cnt), 3);
        relock(n);
        chk("relock_words_after_loss", n, LC + 1);

        // Saturation at 3 with errors spaced by good words
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        repeat (5) begin
            send_bad();
            send_good();
            send_good();
        end
        settle();
        chk("sat_count", int'(cnt), CMAX);
        chk("sat_still_locked", int'(locked), 1);
        drive(1'b1, g ^ 8'h10, 1'b0, 1'b1);
        g = nxt8(g);
        settle();
        chk("clear_wins_count", int'(cnt), 0);
        chk("clear_wins_err", int'(err), 1);

        // All-ones words never seed a lock
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (10) drive(1'b1, 8'hFF, 1'b0, 1'b0);
        settle();
        chk("ff_never_locks", int'(locked), 0);
        chk("ff_count_zero", int'(cnt), 0);

        // Lock on a random seed with gaps, then reset asynchronously mid-error-pulse
        g = 8'($urandom_range(0, 254));
        relock(n);
        chk("relock_random_seed", n, LC + 1);
        send_bad();
        settle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_locked", int'(locked), 0);
        chk("async_rst_err", int'(err), 0);
        chk("async_rst_count", int'(cnt), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        relock(n);
        chk("relock_after_reset", n, LC + 1);

        // Resync pulse with DV: unlock next cycle, count preserved
        send_bad();
        send_good();
        drive(1'b1, g, 1'b1, 1'b0);
        g = nxt8(g);
        settle();
        chk("resync_unlocked", int'(locked), 0);
        chk("resync_keeps_count", int'(cnt), 1);
        relock(n);
        chk("relock_after_resync", n, LC + 1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            dvb = ($urandom_range(0, 99) < 75);
            if (dvb) begin
                d = g;
                if ($urandom_range(0, 15) == 0) d = g ^ 8'(1 << $urandom_range(0, 7));
                g = nxt8(g);
            end else begin
                d = 8'($urandom);
            end
            drive(dvb, d, ($urandom_range(0, 63) == 0), ($urandom_range(0, 63) == 0));
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        n = 0;
        while (sb.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
